// File: rtl/ssemi_halfband_coeff_loader_if.sv
// Tap-write channel from the register block and the parallel coefficient
// channel towards the halfband filter, bundled for the coefficient loader.
interface ssemi_halfband_coeff_loader_if #(
  parameter int NUM_TAPS    = 23,
  parameter int COEFF_WIDTH = 18
);
  localparam int AW = $clog2(NUM_TAPS);

  // Write handshake: one tap transfers on each rising clock edge where wr_valid
  // and wr_ready are both high; wr_valid never waits on wr_ready, and
  // wr_addr/wr_data are held stable while wr_valid is high and not yet accepted.
  logic                            wr_valid;
  logic                            wr_ready;
  logic [AW-1:0]                   wr_addr;
  logic [COEFF_WIDTH-1:0]          wr_data;

  logic                            filt_busy;
  logic                            filt_coeff_ready;
  logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff;
  logic                            coeff_valid;

  modport master (
    output wr_valid, wr_addr, wr_data, filt_busy, filt_coeff_ready,
    input  wr_ready, coeff, coeff_valid
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, filt_busy, filt_coeff_ready,
    output wr_ready, coeff, coeff_valid
  );
endinterface

// File: rtl/ssemi_halfband_coeff_loader.sv
// Halfband coefficient loader: shadow bank writes, halfband structure check on
// commit, then a single-cycle apply of the whole bank once the filter is idle.
module ssemi_halfband_coeff_loader #(
  parameter int NUM_TAPS       = 23,
  parameter int COEFF_WIDTH    = 18,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_enable,
  input  logic                         i_commit,
  input  logic                         i_err_clear,
  ssemi_halfband_coeff_loader_if.slave bus,
  output logic                         o_done,
  output logic [1:0]                   o_state,
  output logic                         o_err_addr,
  output logic                         o_err_odd_tap,
  output logic                         o_err_symmetry,
  output logic                         o_err_timeout
);
  localparam int AW = $clog2(NUM_TAPS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = NUM_TAPS * COEFF_WIDTH;

  localparam logic [AW-1:0] LAST_TAP   = AW'(NUM_TAPS - 1);
  localparam logic [AW-1:0] CENTRE_TAP = AW'((NUM_TAPS - 1) / 2);
  localparam logic [AW:0]   TAP_COUNT  = (AW+1)'(NUM_TAPS);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WAIT  = 2'd2,
    ST_APPLY = 2'd3
  } state_t;

  state_t                 state;
  logic [AW-1:0]          tap_idx;
  logic [TW-1:0]          tmo_cnt;
  logic                   acc_odd;
  logic                   acc_sym;
  logic                   apply_q;
  logic [BW-1:0]          active_q;
  logic [BW-1:0]          shadow_flat;
  logic [COEFF_WIDTH-1:0] shadow [NUM_TAPS];

  logic                   wr_ready;
  logic                   wr_fire;
  logic                   addr_ok;
  logic [AW-1:0]          mirror_idx;
  logic [COEFF_WIDTH-1:0] tap_k;
  logic [COEFF_WIDTH-1:0] tap_m;
  logic                   cur_odd;
  logic                   cur_sym;
  logic                   check_end;
  logic                   filt_ok;
  logic                   set_addr;
  logic                   set_odd;
  logic                   set_sym;
  logic                   set_time;

  always_comb begin
    wr_ready   = i_enable && (state == ST_IDLE);
    wr_fire    = bus.wr_valid && wr_ready;
    addr_ok    = {1'b0, bus.wr_addr} < TAP_COUNT;
    mirror_idx = LAST_TAP - tap_idx;
    tap_k      = shadow[tap_idx];
    tap_m      = shadow[mirror_idx];
    // The centre tap is the one odd index allowed to be nonzero.
    cur_odd    = tap_idx[0] && (tap_idx != CENTRE_TAP) && (tap_k != '0);
    cur_sym    = tap_k != tap_m;
    check_end  = i_enable && (state == ST_CHECK) && (tap_idx == LAST_TAP);
    filt_ok    = !bus.filt_busy && bus.filt_coeff_ready;
    set_addr   = wr_fire && !addr_ok;
    set_odd    = check_end && (acc_odd || cur_odd);
    set_sym    = check_end && (acc_sym || cur_sym);
    set_time   = i_enable && (state == ST_WAIT) && !filt_ok && (tmo_cnt == TMO_LAST);
  end

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      shadow_flat[i*COEFF_WIDTH +: COEFF_WIDTH] = shadow[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_fire && addr_ok) begin
      shadow[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      tap_idx  <= '0;
      tmo_cnt  <= '0;
      acc_odd  <= 1'b0;
      acc_sym  <= 1'b0;
      apply_q  <= 1'b0;
      active_q <= '0;
    end else begin
      apply_q <= 1'b0;
      if (!i_enable) begin
        state   <= ST_IDLE;
        tap_idx <= '0;
        tmo_cnt <= '0;
        acc_odd <= 1'b0;
        acc_sym <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_commit) begin
              state   <= ST_CHECK;
              tap_idx <= '0;
              acc_odd <= 1'b0;
              acc_sym <= 1'b0;
            end
          end
          ST_CHECK: begin
            acc_odd <= acc_odd || cur_odd;
            acc_sym <= acc_sym || cur_sym;
            if (tap_idx == LAST_TAP) begin
              tap_idx <= '0;
              tmo_cnt <= '0;
              state   <= (set_odd || set_sym) ? ST_IDLE : ST_WAIT;
            end else begin
              tap_idx <= tap_idx + 1'b1;
            end
          end
          ST_WAIT: begin
            if (filt_ok) begin
              // The bank swap and the strobe share this edge so the filter
              // sees new coefficients in the same cycle as coeff_valid.
              state    <= ST_APPLY;
              active_q <= shadow_flat;
              apply_q  <= 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
              state   <= ST_IDLE;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          ST_APPLY: state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  // A flag raised in the same cycle as i_err_clear survives the clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err_addr     <= 1'b0;
      o_err_odd_tap  <= 1'b0;
      o_err_symmetry <= 1'b0;
      o_err_timeout  <= 1'b0;
    end else begin
      o_err_addr     <= (o_err_addr     && !i_err_clear) || set_addr;
      o_err_odd_tap  <= (o_err_odd_tap  && !i_err_clear) || set_odd;
      o_err_symmetry <= (o_err_symmetry && !i_err_clear) || set_sym;
      o_err_timeout  <= (o_err_timeout  && !i_err_clear) || set_time;
    end
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.coeff       = active_q;
  assign bus.coeff_valid = apply_q;
  assign o_done          = apply_q;
  assign o_state         = state;
endmodule
